// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: two-requester round-robin arbiter feeding one RMII frame transmitter.
//
// A requester that wins arbitration owns the transmitter for one whole frame. Its beats go out
// on tx_data one cycle after acceptance. Frames that underrun (the owner drops valid mid-frame)
// or run past MAX_BEATS are drained to their last beat without being forwarded. Once the
// transmitter reports idle, a fixed inter-frame gap is inserted before the next grant.
//
// Ports
//   clk, rstn                  clock and asynchronous active-low reset
//   reqN_valid/data/last       payload beat from requester N (N = 0, 1)
//   reqN_ready                 beat from requester N accepted this cycle
//   tx_busy                    frame transmitter still emitting a frame
//   tx_valid, tx_data          registered payload beat to the transmitter
//   grant                      one-hot owner of the transmitter, 00 when none
//   underrun_count             saturating count of frames aborted by a valid drop
//   oversize_count             saturating count of frames truncated at MAX_BEATS
`timescale 1ns/1ps
module eth_tx_arbiter #(
    parameter int unsigned W          = 2,
    parameter int unsigned IFG_CYCLES = 48,
    parameter int unsigned MAX_BEATS  = 6000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    input  logic         req0_last,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    input  logic         req1_last,
    output logic         req1_ready,
    input  logic         tx_busy,
    output logic         tx_valid,
    output logic [W-1:0] tx_data,
    output logic [1:0]   grant,
    output logic [7:0]   underrun_count,
    output logic [7:0]   oversize_count
);

    localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
    localparam int unsigned GapW  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StFlush,
        StWaitDone,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    // 0: req0 wins the next contention, 1: req1 wins it.
    logic             rr_q, rr_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             tx_valid_q, tx_valid_d;
    logic [W-1:0]     tx_data_q, tx_data_d;
    logic [7:0]       underrun_q, underrun_d;
    logic [7:0]       oversize_q, oversize_d;

    logic             in_xfer;
    logic             own_valid;
    logic [W-1:0]     own_data;
    logic             own_last;

    // The granted requester sees ready in both SEND and FLUSH; tx_busy never reaches ready.
    assign in_xfer    = (state_q == StSend) || (state_q == StFlush);
    assign req0_ready = in_xfer & grant_q[0];
    assign req1_ready = in_xfer & grant_q[1];

    assign own_valid  = grant_q[1] ? req1_valid : req0_valid;
    assign own_data   = grant_q[1] ? req1_data  : req0_data;
    assign own_last   = grant_q[1] ? req1_last  : req0_last;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        underrun_d = underrun_q;
        oversize_d = oversize_q;

        unique case (state_q)
            StIdle: begin
                if (!tx_busy && (req0_valid || req1_valid)) begin
                    // A lone requester wins regardless of the pointer.
                    if (req0_valid && (!req1_valid || !rr_q)) begin
                        grant_d = 2'b01;
                    end else begin
                        grant_d = 2'b10;
                    end
                    beat_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (own_valid) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = own_data;
                    beat_d     = beat_q + BeatW'(1);
                    if (own_last) begin
                        state_d = StWaitDone;
                    end else if (beat_q == BeatW'(MAX_BEATS - 1)) begin
                        // The MAX_BEATS-th beat is still forwarded; the rest is drained.
                        state_d = StFlush;
                        if (oversize_q != 8'hff) begin
                            oversize_d = oversize_q + 8'd1;
                        end
                    end
                end else begin
                    state_d = StFlush;
                    if (underrun_q != 8'hff) begin
                        underrun_d = underrun_q + 8'd1;
                    end
                end
            end
            StFlush: begin
                if (own_valid && own_last) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    gap_d   = GapW'(IFG_CYCLES);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    grant_d = 2'b00;
                    rr_d    = grant_q[0];
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            grant_q    <= 2'b00;
            rr_q       <= 1'b0;
            beat_q     <= '0;
            gap_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            underrun_q <= 8'd0;
            oversize_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            underrun_q <= underrun_d;
            oversize_q <= oversize_d;
        end
    end

    assign tx_valid       = tx_valid_q;
    assign tx_data        = tx_data_q;
    assign grant          = grant_q;
    assign underrun_count = underrun_q;
    assign oversize_count = oversize_q;

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 Parameter W, default 2: data beat width in bits, matching the RMII transmit data width.
REQ-002 Parameter IFG_CYCLES, default 48: idle cycles inserted between frames (96 bit times at 2 bits/cycle).
REQ-003 Parameter MAX_BEATS, default 6000: maximum payload beats per frame (1500 bytes at W=2).
REQ-004 clk  in  1  single clock for the whole block (RMII reference clock domain).
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester i has a payload beat.
REQ-007 req0_data / req1_data  in  W each  payload beat of requester i.
REQ-008 req0_last / req1_last  in  1 each  beat is the final beat of the frame.
REQ-009 req0_ready / req1_ready  out  1 each  arbiter accepts the beat this cycle.
REQ-010 tx_busy  in  1  frame transmitter still emitting a frame (its output-valid).
REQ-011 tx_valid  out  1  payload beat to the frame transmitter.
REQ-012 tx_data  out  W  payload beat data.
REQ-013 grant  out  2  one-hot owner of the transmitter; 00 when none.
REQ-014 underrun_count  out  8  saturating count of frames aborted by a valid drop.
REQ-015 oversize_count  out  8  saturating count of frames truncated at MAX_BEATS.

Function
REQ-016 The FSM shall have states IDLE, SEND, FLUSH, WAIT_DONE, GAP.
REQ-017 IDLE: when tx_busy=0 and any req valid, the arbiter shall set grant to the winner and enter SEND on the next cycle.
REQ-018 Arbitration shall be round-robin: on contention, the requester not granted most recently wins; after reset req0 wins first.
REQ-019 Single requester valid shall be granted regardless of round-robin pointer.
REQ-020 SEND: reqi_ready=1 for the granted requester only, combinationally from state and grant; ungranted ready is always 0.
REQ-021 Each accepted beat (valid & ready) shall appear on tx_data with tx_valid=1 exactly one cycle later (registered, latency 1).
REQ-022 Acceptance of a beat with last=1 shall transition to WAIT_DONE; tx_valid shall drop the cycle after the last beat is presented.
REQ-023 Granted valid=0 in SEND (underrun) shall transition to FLUSH; tx_valid=0 next cycle; underrun_count increments, saturating at 255.
REQ-024 A beat counter shall count accepted beats in SEND; acceptance of beat MAX_BEATS without last shall transition to FLUSH and increment oversize_count (saturating); beat MAX_BEATS itself is forwarded.
REQ-025 FLUSH: granted ready=1, accepted beats are discarded (tx_valid=0); acceptance of a last beat transitions to WAIT_DONE.
REQ-026 WAIT_DONE: remain until tx_busy=0, then load gap counter with IFG_CYCLES and enter GAP.
REQ-027 GAP: decrement each cycle; at zero, clear grant, update round-robin pointer and enter IDLE; total idle between tx_busy fall and next grant is IFG_CYCLES+1 cycles.
REQ-028 grant shall remain stable from IDLE exit until IDLE re-entry.
REQ-029 A requester asserting valid during another's frame shall be held (ready=0) without loss; its data must remain stable.
REQ-030 Beat counter shall be cleared on every IDLE->SEND transition.

Reset
REQ-031 rstn=0 shall asynchronously force state IDLE, grant=00, tx_valid=0, tx_data=0, both readys=0, both counters=0, gap/beat counters=0, pointer favoring req0.
REQ-032 Reset asserted mid-frame shall abort immediately; after release no partial beats are emitted and arbitration restarts from IDLE.
REQ-033 Outputs shall be driven from registers or state decode only; no path from tx_busy to readys.

Verification
REQ-034 Both requesters raise valid in same cycle with 4-beat frames, tx_busy pulsed 10 cycles after each last -> req0 granted first, tx_data matches req0 beats with 1-cycle latency, then req1 after 48 gap cycles.
REQ-035 req1 sends three consecutive frames while req0 idle, then req0 and req1 both request -> req0 wins; next contention req1 wins.
REQ-036 req0 drops valid after beat 3 of 8, later sends remaining 5 with last -> tx_valid=0 from beat 4 onward, 5 beats accepted and discarded, underrun_count=1.
REQ-037 MAX_BEATS=16, req0 sends 20-beat frame -> exactly 16 beats on tx, 4 flushed, oversize_count=1, grant returns 00 after gap.
REQ-038 rstn pulsed low for 1 cycle during beat 5 of a frame -> all outputs 0 asynchronously, grant=00, next request granted cleanly from IDLE.
REQ-039 Drive 300 underrun frames -> underrun_count saturates at 255.
